// File: rtl/decode_pkg.sv
// decode_pkg: MIPS instruction field positions and queue/decoder data types.
package decode_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SA_HI  = 10, SA_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int IDX_HI = 25, IDX_LO = 0;
  localparam int SEL_HI = 2,  SEL_LO = 0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic [31:0] imm32s;
    logic [31:0] imm32l;
    logic [31:0] imm32i;
    logic [31:0] sa32;
    logic [25:0] index;
    logic [2:0]  sel;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
  } dec_t;
endpackage

// File: rtl/inst_field_extract.sv
// inst_field_extract: combinational field split, immediate extension and branch/jump targets.
module inst_field_extract
  import decode_pkg::*;
(
  input  entry_t ent_i,
  output dec_t   dec_o
);
  logic [31:0] pc4;
  logic [15:0] imm;
  always_comb begin
    pc4          = ent_i.pc + 32'd4;
    imm          = ent_i.inst[IMM_HI:IMM_LO];
    dec_o.op     = ent_i.inst[OP_HI:OP_LO];
    dec_o.func   = ent_i.inst[FN_HI:FN_LO];
    dec_o.rs     = ent_i.inst[RS_HI:RS_LO];
    dec_o.rt     = ent_i.inst[RT_HI:RT_LO];
    dec_o.rd     = ent_i.inst[RD_HI:RD_LO];
    dec_o.sa     = ent_i.inst[SA_HI:SA_LO];
    dec_o.imm16  = imm;
    dec_o.imm32s = {{16{imm[15]}}, imm};
    dec_o.imm32l = {16'b0, imm};
    dec_o.imm32i = {{14{imm[15]}}, imm, 2'b00};
    dec_o.sa32   = {27'b0, ent_i.inst[SA_HI:SA_LO]};
    dec_o.index  = ent_i.inst[IDX_HI:IDX_LO];
    dec_o.sel    = ent_i.inst[SEL_HI:SEL_LO];
    dec_o.br_tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
    dec_o.j_tgt  = {pc4[31:28], ent_i.inst[IDX_HI:IDX_LO], 2'b00};
  end
endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: multi-lane circular instruction queue presenting decoded head lanes.
module inst_decode_queue
  import decode_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(OUT_W + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic [IN_W-1:0]     in_valid_i,
  input  logic [32*IN_W-1:0]  in_inst_i,
  input  logic [32*IN_W-1:0]  in_pc_i,
  output logic                in_ready_o,
  output logic [OUT_W-1:0]    out_valid_o,
  input  logic [AW-1:0]       out_accept_i,
  output logic [32*OUT_W-1:0] out_pc_o,
  output logic [32*OUT_W-1:0] out_inst_o,
  output logic [6*OUT_W-1:0]  out_op_o,
  output logic [6*OUT_W-1:0]  out_func_o,
  output logic [5*OUT_W-1:0]  out_rs_o,
  output logic [5*OUT_W-1:0]  out_rt_o,
  output logic [5*OUT_W-1:0]  out_rd_o,
  output logic [5*OUT_W-1:0]  out_sa_o,
  output logic [16*OUT_W-1:0] out_imm16_o,
  output logic [32*OUT_W-1:0] out_imm32s_o,
  output logic [32*OUT_W-1:0] out_imm32l_o,
  output logic [32*OUT_W-1:0] out_imm32i_o,
  output logic [32*OUT_W-1:0] out_sa32_o,
  output logic [26*OUT_W-1:0] out_index_o,
  output logic [3*OUT_W-1:0]  out_sel_o,
  output logic [32*OUT_W-1:0] out_br_tgt_o,
  output logic [32*OUT_W-1:0] out_j_tgt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   npush, npop, vcnt, acc;
  logic [PW-1:0]   wr_idx [IN_W];
  logic            push_en;

  assign in_ready_o = count_q <= CW'(DEPTH - IN_W);
  assign push_en    = in_ready_o & (|in_valid_i) & ~flush_i;

  // Valid slots are packed densely from tail in ascending slot order.
  always_comb begin
    npush = '0;
    for (int i = 0; i < IN_W; i++) begin
      wr_idx[i] = tail_q + PW'(npush);
      npush     = in_valid_i[i] ? npush + CW'(1) : npush;
    end
    vcnt    = count_q > CW'(OUT_W) ? CW'(OUT_W) : count_q;
    acc     = CW'(out_accept_i);
    npop    = acc < vcnt ? acc : vcnt;
    head_d  = flush_i ? '0 : head_q + PW'(npop);
    tail_d  = flush_i ? '0 : push_en ? tail_q + PW'(npush) : tail_q;
    count_d = flush_i ? '0 : count_q + (push_en ? npush : '0) - npop;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en)
      for (int i = 0; i < IN_W; i++)
        if (in_valid_i[i]) mem_q[wr_idx[i]] <= {in_pc_i[i*32+:32], in_inst_i[i*32+:32]};
  end

  for (genvar k = 0; k < OUT_W; k++) begin : g_lane
    entry_t ent, ent_v;
    dec_t   raw, dec;
    assign out_valid_o[k] = count_q > CW'(k);
    assign ent            = mem_q[head_q + PW'(k)];
    assign ent_v          = out_valid_o[k] ? ent : '0;
    assign dec            = out_valid_o[k] ? raw : '0;
    inst_field_extract u_ext (.ent_i(ent_v), .dec_o(raw));
    assign out_pc_o[k*32+:32]     = ent_v.pc;
    assign out_inst_o[k*32+:32]   = ent_v.inst;
    assign out_op_o[k*6+:6]       = dec.op;
    assign out_func_o[k*6+:6]     = dec.func;
    assign out_rs_o[k*5+:5]       = dec.rs;
    assign out_rt_o[k*5+:5]       = dec.rt;
    assign out_rd_o[k*5+:5]       = dec.rd;
    assign out_sa_o[k*5+:5]       = dec.sa;
    assign out_imm16_o[k*16+:16]  = dec.imm16;
    assign out_imm32s_o[k*32+:32] = dec.imm32s;
    assign out_imm32l_o[k*32+:32] = dec.imm32l;
    assign out_imm32i_o[k*32+:32] = dec.imm32i;
    assign out_sa32_o[k*32+:32]   = dec.sa32;
    assign out_index_o[k*26+:26]  = dec.index;
    assign out_sel_o[k*3+:3]      = dec.sel;
    assign out_br_tgt_o[k*32+:32] = dec.br_tgt;
    assign out_j_tgt_o[k*32+:32]  = dec.j_tgt;
  end
endmodule
